turf_tally: RTL and testbench



---
 rtl/turf_tally.sv | 172 +++++++++++++++++
 tb/tb_turf_tally.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/turf_tally.sv
// End-of-round turf scorer: scans the paint framebuffer once, tallies cells per
// player colour plus unpainted cells, then picks the winner and flags ties.
module turf_tally #(
  parameter int NUM_PLAYERS = 4,
  parameter int COLOR_W = 3,
  parameter logic [NUM_PLAYERS*COLOR_W-1:0] PLAYER_COLORS = {3'b110, 3'b100, 3'b010, 3'b001},
  parameter int X_BITS = 8,
  parameter int Y_BITS = 7,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119,
  parameter int RD_LATENCY = 1,
  localparam int CNT_W = X_BITS + Y_BITS,
  localparam int WIN_W = $clog2(NUM_PLAYERS)
) (
  input  logic                         CLOCK_50,
  input  logic                         resetn,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [X_BITS+Y_BITS-1:0]     address,
  input  logic [COLOR_W-1:0]           q,
  output logic [NUM_PLAYERS*CNT_W-1:0] counts,
  output logic [CNT_W-1:0]             unpainted,
  output logic [WIN_W-1:0]             winner,
  output logic                         tie
);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DRAIN, S_COMPARE, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [X_BITS-1:0]       x_q, x_d;
  logic [Y_BITS-1:0]       y_q, y_d;
  logic                    end_q, end_d;
  logic [RD_LATENCY-1:0]   vld_q, vld_d;
  logic [1:0]              dcnt_q, dcnt_d;
  logic [WIN_W-1:0]        pidx_q, pidx_d;
  logic [CNT_W-1:0]        cnt_q [NUM_PLAYERS];
  logic [CNT_W-1:0]        cnt_d [NUM_PLAYERS];
  logic [CNT_W-1:0]        unp_q, unp_d;
  logic [CNT_W-1:0]        max_q, max_d;
  logic [WIN_W-1:0]        win_q, win_d;
  logic                    tie_q, tie_d;
  logic                    issue;
  logic                    hit;
  logic [WIN_W-1:0]        hit_idx;

  // Walk downwards so the lowest-index player owning a duplicated colour wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (q == PLAYER_COLORS[i*COLOR_W +: COLOR_W]) begin
        hit     = 1'b1;
        hit_idx = WIN_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    end_d   = end_q;
    dcnt_d  = dcnt_q;
    pidx_d  = pidx_q;
    cnt_d   = cnt_q;
    unp_d   = unp_q;
    max_d   = max_q;
    win_d   = win_q;
    tie_d   = tie_q;
    // end_q marks the extra SCAN cycle that holds the final address untagged.
    issue   = (state_q == S_SCAN) && !end_q;
    vld_d   = RD_LATENCY'({vld_q, issue});

    if (vld_q[RD_LATENCY-1]) begin
      if (hit) cnt_d[hit_idx] = cnt_q[hit_idx] + CNT_W'(1);
      else     unp_d = unp_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SCAN;
          x_d     = '0;
          y_d     = '0;
          end_d   = 1'b0;
          for (int i = 0; i < NUM_PLAYERS; i++) cnt_d[i] = '0;
          unp_d   = '0;
          max_d   = '0;
          win_d   = '0;
          tie_d   = 1'b0;
        end
      end
      S_SCAN: begin
        if (end_q) begin
          state_d = S_DRAIN;
          dcnt_d  = '0;
        end else if (x_q == X_BITS'(X_MAX) && y_q == Y_BITS'(Y_MAX)) begin
          end_d = 1'b1;
        end else if (y_q == Y_BITS'(Y_MAX)) begin
          y_d = '0;
          x_d = x_q + X_BITS'(1);
        end else begin
          y_d = y_q + Y_BITS'(1);
        end
      end
      S_DRAIN: begin
        if (dcnt_q == 2'(RD_LATENCY - 1)) begin
          state_d = S_COMPARE;
          pidx_d  = '0;
        end else begin
          dcnt_d = dcnt_q + 2'd1;
        end
      end
      S_COMPARE: begin
        // Running max starts at zero, so an all-zero board reports a tie at player 0.
        if (cnt_q[pidx_q] > max_q) begin
          max_d = cnt_q[pidx_q];
          win_d = pidx_q;
          tie_d = 1'b0;
        end else if (cnt_q[pidx_q] == max_q) begin
          tie_d = 1'b1;
        end
        if (pidx_q == WIN_W'(NUM_PLAYERS - 1)) state_d = S_DONE;
        else                                   pidx_d  = pidx_q + WIN_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      end_q   <= 1'b0;
      vld_q   <= '0;
      dcnt_q  <= '0;
      pidx_q  <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) cnt_q[i] <= '0;
      unp_q   <= '0;
      max_q   <= '0;
      win_q   <= '0;
      tie_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      end_q   <= end_d;
      vld_q   <= vld_d;
      dcnt_q  <= dcnt_d;
      pidx_q  <= pidx_d;
      cnt_q   <= cnt_d;
      unp_q   <= unp_d;
      max_q   <= max_d;
      win_q   <= win_d;
      tie_q   <= tie_d;
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pack
    assign counts[g*CNT_W +: CNT_W] = cnt_q[g];
  end

  assign address   = {x_q, y_q};
  assign unpainted = unp_q;
  assign winner    = win_q;
  assign tie       = tie_q;
  assign busy      = (state_q == S_SCAN) || (state_q == S_DRAIN) || (state_q == S_COMPARE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_turf_tally.sv
// Directed bench for turf_tally: small 4x3 boards, a 2-player latency-3 board
// and the full default-size address sweep.
module tb_turf_tally;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;
  logic st_s, st_d, st_l;
  logic [2:0] mem [0:32767];

  // 4-player, 4x3 board, latency 1
  logic        busy_s, done_s, tie_s;
  logic [14:0] addr_s, unp_s;
  logic [2:0]  q_s, ps0;
  logic [59:0] cnt_s;
  logic [1:0]  win_s;

  // default configuration
  logic        busy_d, done_d, tie_d;
  logic [14:0] addr_d, unp_d;
  logic [2:0]  q_d, pd0;
  logic [59:0] cnt_d;
  logic [1:0]  win_d;

  // 2-player, 4x3 board, latency 3
  logic        busy_l, done_l, tie_l;
  logic [14:0] addr_l, unp_l;
  logic [2:0]  q_l, pl0, pl1, pl2;
  logic [29:0] cnt_l;
  logic [0:0]  win_l;

  turf_tally #(.X_MAX(3), .Y_MAX(2)) u_small (
    .CLOCK_50(clk), .resetn(resetn), .start(st_s), .busy(busy_s), .done(done_s),
    .address(addr_s), .q(q_s), .counts(cnt_s), .unpainted(unp_s), .winner(win_s), .tie(tie_s));

  turf_tally u_dflt (
    .CLOCK_50(clk), .resetn(resetn), .start(st_d), .busy(busy_d), .done(done_d),
    .address(addr_d), .q(q_d), .counts(cnt_d), .unpainted(unp_d), .winner(win_d), .tie(tie_d));

  turf_tally #(.NUM_PLAYERS(2), .PLAYER_COLORS(6'b100_001), .X_MAX(3), .Y_MAX(2),
               .RD_LATENCY(3)) u_lat3 (
    .CLOCK_50(clk), .resetn(resetn), .start(st_l), .busy(busy_l), .done(done_l),
    .address(addr_l), .q(q_l), .counts(cnt_l), .unpainted(unp_l), .winner(win_l), .tie(tie_l));

  always @(posedge clk) begin
    ps0 <= mem[addr_s];
    pd0 <= mem[addr_d];
    pl0 <= mem[addr_l];
    pl1 <= pl0;
    pl2 <= pl1;
  end
  assign q_s = ps0;
  assign q_d = pd0;
  assign q_l = pl2;

  int   n_checks = 0;
  int   n_fail = 0;
  int   addr_err;
  int   bad_seen;
  logic post_clear;
  int   cyc;
  logic [35:0] pat;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32768; i++) mem[i] = 3'b000;
  endtask

  // Cell k of the 4x3 board sits at x=k/3, y=k%3.
  task automatic load_cells(input logic [35:0] p);
    for (int k = 0; k < 12; k++) mem[{8'(k / 3), 7'(k % 3)}] = p[k*3 +: 3];
  endtask

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0: st_s = v;
      1: st_d = v;
      default: st_l = v;
    endcase
  endtask

  function automatic logic get_done(input int sel);
    case (sel)
      0: return done_s;
      1: return done_d;
      default: return done_l;
    endcase
  endfunction

  // Returns the number of edges after the start edge until done is seen.
  task automatic run_scan(input int sel, input int hold, output int c);
    int k;
    logic [7:0] ex;
    logic [6:0] ey;
    k = 0; ex = '0; ey = '0; c = -1;
    addr_err = 0; bad_seen = 0;
    set_start(sel, 1'b1);
    tick();
    if (hold == 0) set_start(sel, 1'b0);
    post_clear = (cnt_s == '0) && (unp_s == '0) && (win_s == '0) && (tie_s == 1'b0) && busy_s;
    for (int n = 1; n <= 25000; n++) begin
      if (sel == 1) begin
        if (k < 19200) begin
          if (addr_d !== {ex, ey}) addr_err++;
          k++;
          if (ey == 7'd119) begin ey = '0; ex++; end
          else ey++;
        end
        if (addr_d[6:0] > 7'd119 || addr_d[14:7] > 8'd159) bad_seen++;
      end
      tick();
      if (n >= hold) set_start(sel, 1'b0);
      if (get_done(sel)) begin
        c = n;
        break;
      end
    end
    if (c < 0) check_val("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    resetn = 1'b0;
    st_s = 1'b0; st_d = 1'b0; st_l = 1'b0;
    clear_mem();
    tick(); tick();
    check_val("rst_busy", busy_s, 0);
    check_val("rst_done", done_s, 0);
    check_val("rst_addr", addr_s, 0);
    check_val("rst_counts", cnt_s, 0);
    check_val("rst_unp", unp_s, 0);
    check_val("rst_win", win_s, 0);
    check_val("rst_tie", tie_s, 0);
    resetn = 1'b1;
    tick();

    // all cells owned by player 0
    pat = {12{3'b001}};
    load_cells(pat);
    run_scan(0, 0, cyc);
    check_val("t1_cycles", cyc, 18);
    check_val("t1_counts", cnt_s, {15'd0, 15'd0, 15'd0, 15'd12});
    check_val("t1_unp", unp_s, 0);
    check_val("t1_win", win_s, 0);
    check_val("t1_tie", tie_s, 0);
    check_val("t1_busy", busy_s, 0);

    // mixed board, restarted from DONE
    pat = {3'b111, 3'b000, 3'b110, 3'b110, 3'b110, 3'b110,
           3'b100, 3'b100, 3'b100, 3'b010, 3'b010, 3'b001};
    load_cells(pat);
    run_scan(0, 0, cyc);
    check_val("t2_clear_on_start", post_clear, 1);
    check_val("t2_p0", cnt_s[0 +: 15], 1);
    check_val("t2_p1", cnt_s[15 +: 15], 2);
    check_val("t2_p2", cnt_s[30 +: 15], 3);
    check_val("t2_p3", cnt_s[45 +: 15], 4);
    check_val("t2_unp", unp_s, 2);
    check_val("t2_win", win_s, 3);
    check_val("t2_tie", tie_s, 0);

    // p1 and p3 tie at five cells
    pat = {3'b000, 3'b000, {5{3'b110}}, {5{3'b010}}};
    load_cells(pat);
    run_scan(0, 0, cyc);
    check_val("t3_counts", cnt_s, {15'd5, 15'd0, 15'd5, 15'd0});
    check_val("t3_unp", unp_s, 2);
    check_val("t3_win", win_s, 1);
    check_val("t3_tie", tie_s, 1);

    // start held high through part of the scan must not restart it
    pat = {12{3'b001}};
    load_cells(pat);
    run_scan(0, 10, cyc);
    check_val("t4_cycles", cyc, 18);
    check_val("t4_p0", cnt_s[0 +: 15], 12);
    tick(); tick(); tick();
    check_val("t4_done_hold", done_s, 1);
    check_val("t4_counts_hold", cnt_s, {15'd0, 15'd0, 15'd0, 15'd12});

    // reset in the middle of a scan
    st_s = 1'b1;
    tick();
    st_s = 1'b0;
    repeat (5) tick();
    check_val("t5_busy_mid", busy_s, 1);
    check_val("t5_p0_mid", cnt_s[0 +: 15], 4);
    resetn = 1'b0;
    tick();
    check_val("t5_busy", busy_s, 0);
    check_val("t5_done", done_s, 0);
    check_val("t5_addr", addr_s, 0);
    check_val("t5_counts", cnt_s, 0);
    check_val("t5_unp", unp_s, 0);
    check_val("t5_win", win_s, 0);
    check_val("t5_tie", tie_s, 0);
    resetn = 1'b1;
    tick(); tick();
    check_val("t5_idle_busy", busy_s, 0);
    check_val("t5_idle_done", done_s, 0);

    // two players, latency 3, six cells each
    pat = {{6{3'b100}}, {6{3'b001}}};
    load_cells(pat);
    run_scan(2, 0, cyc);
    check_val("t6_cycles", cyc, 18);
    check_val("t6_counts", cnt_l, {15'd6, 15'd6});
    check_val("t6_unp", unp_l, 0);
    check_val("t6_win", win_l, 0);
    check_val("t6_tie", tie_l, 1);

    // full-size sweep over an empty board
    clear_mem();
    run_scan(1, 0, cyc);
    check_val("t7_cycles", cyc, 19206);
    check_val("t7_addr_seq_err", addr_err, 0);
    check_val("t7_bad_addr", bad_seen, 0);
    check_val("t7_last_addr", addr_d, 15'h4FF7);
    check_val("t7_unp", unp_d, 19200);
    check_val("t7_counts", cnt_d, 0);
    check_val("t7_win", win_d, 0);
    check_val("t7_tie", tie_d, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
